// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions. The monitor and the display controller both
// import this package so the nominal 640x480 timing lives in exactly one place.
//
// Contents:
//   CNT_W / CNT_MAX      width and saturation value of all 10-bit counters
//   *_DEF                default 640x480@60 timing constants
//   mon_state_e          monitor lock state machine encoding
//   sat_inc()            saturating +1 on a CNT_W-bit counter
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // 640x480@60: 800 pixel periods per line, 525 lines per frame.
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 783;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 514;
  localparam int LOCK_LINES_DEF  = 4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,  // waiting for the first hSync edge
    ST_H_TRACK = 2'd1,  // counting good lines, waiting for a good frame
    ST_LOCKED  = 2'd2   // line and frame lengths match nominal timing
  } mon_state_e;

  // Counters stick at CNT_MAX instead of wrapping, so a dead sync input shows
  // up as a pinned value rather than a plausible-looking count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Falling-edge detector for an active-low sync that is already synchronous to
// the clock. The input is only sampled on pixel-enable cycles, so an "edge" is
// a pixel sample at 0 whose previous pixel sample was 1.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   synchronous active-low reset; previous sample resets to 1 (idle)
//   i_pix_en  pixel-rate enable
//   i_sync_n  active-low sync input
//   o_fall    combinational strobe, high on the pixel sample that sees the edge
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_en,
  input  logic i_sync_n,
  output logic o_fall
);

  logic r_prev;

  // NOTE: reset is sampled inside the clocked block (synchronous); it is not
  // in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
    end else if (i_pix_en) begin
      // NOTE: non-blocking assignment for every flop so all registers update
      // from pre-edge values regardless of statement order.
      r_prev <= i_sync_n;
    end
  end

  // Strobe is valid in the same cycle as the sample, so the counters can act
  // on it without an extra pipeline stage.
  assign o_fall = i_pix_en & r_prev & ~i_sync_n;

endmodule

// File: rtl/vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor
// Recovers pixel/line position from an incoming VGA hSync/vSync pair, measures
// line and frame lengths, and declares lock when both match nominal timing.
//
// Ports:
//   ClkPort      system clock (100 MHz), all logic on its rising edge
//   Reset_n      synchronous active-low reset
//   pix_en       pixel-rate enable; all sampling and counting happen only here
//   hSync/vSync  active-low syncs, already synchronous to ClkPort
//   hCount       recovered pixel position in the line (saturates at 1023)
//   vCount       recovered line position in the frame (saturates at 1023)
//   bright       active-video flag, only while locked
//   locked       timing matches H_TOTAL / V_TOTAL
//   line_len     last measured line length in pixel periods
//   frame_lines  last measured frame length in lines
//   frame_start  one-cycle pulse on the pixel sample where vCount reloads to 0
//   sync_err     one-cycle pulse on the pixel sample where lock is lost
// -----------------------------------------------------------------------------
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF,
  parameter int LOCK_LINES  = LOCK_LINES_DEF   // must not exceed 255
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic             pix_en,
  input  logic             hSync,
  input  logic             vSync,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             locked,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             frame_start,
  output logic             sync_err
);

  localparam int MATCH_W = 8;

  localparam logic [CNT_W-1:0]   H_TOTAL_L     = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0]   V_TOTAL_L     = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0]   H_ACT_START_L = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0]   H_ACT_END_L   = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0]   V_ACT_START_L = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0]   V_ACT_END_L   = CNT_W'(V_ACT_END);
  localparam logic [MATCH_W-1:0] LOCK_LINES_L  = MATCH_W'(LOCK_LINES);
  localparam logic [CNT_W-1:0]   H_PRE_SAT     = CNT_MAX - CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  mon_state_e         r_state;
  logic [CNT_W-1:0]   r_hcount;
  logic [CNT_W-1:0]   r_vcount;
  logic [CNT_W-1:0]   r_line_len;
  logic [CNT_W-1:0]   r_frame_lines;
  logic               r_pending;     // vSync edge seen, waiting for hSync edge
  logic [MATCH_W-1:0] r_match;       // consecutive lines of length H_TOTAL

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  mon_state_e         w_state_nxt;
  logic               w_sync_err;
  logic               w_h_edge;
  logic               w_v_edge;
  logic               w_frame_evt;
  logic [CNT_W-1:0]   w_hcount_inc;
  logic [CNT_W-1:0]   w_vcount_inc;
  logic               w_line_ok;
  logic               w_frame_ok;
  logic               w_h_sat_hit;
  logic [MATCH_W-1:0] w_match_inc;
  logic [MATCH_W-1:0] w_match_nxt;

  sync_edge_det u_h_edge (
    .i_clk    (ClkPort),
    .i_rst_n  (Reset_n),
    .i_pix_en (pix_en),
    .i_sync_n (hSync),
    .o_fall   (w_h_edge)
  );

  sync_edge_det u_v_edge (
    .i_clk    (ClkPort),
    .i_rst_n  (Reset_n),
    .i_pix_en (pix_en),
    .i_sync_n (vSync),
    .o_fall   (w_v_edge)
  );

  // hCount+1 / vCount+1 double as the measured length of the line / frame that
  // ends on this hSync edge.
  assign w_hcount_inc = sat_inc(r_hcount);
  assign w_vcount_inc = sat_inc(r_vcount);

  // A frame starts on the hSync edge that coincides with, or follows, a vSync
  // edge; aligning to hSync keeps vCount=0 on a line boundary.
  assign w_frame_evt = w_h_edge & (r_pending | w_v_edge);

  assign w_line_ok  = (w_hcount_inc == H_TOTAL_L);
  assign w_frame_ok = (w_vcount_inc == V_TOTAL_L);

  // The sample on which hCount steps from 1022 to 1023: the line is too long
  // to ever be valid, so the tracker gives up at that moment.
  assign w_h_sat_hit = pix_en & ~w_h_edge & (r_hcount == H_PRE_SAT);

  // Match count including the line ending on this edge, so a frame_start that
  // also closes the LOCK_LINES-th good line can lock immediately.
  assign w_match_inc = (r_match == '1) ? r_match : r_match + MATCH_W'(1);
  assign w_match_nxt = w_line_ok ? w_match_inc : '0;

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise
    // synthesis infers latches for the unassigned branches.
    w_state_nxt = r_state;
    w_sync_err  = 1'b0;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_h_edge) begin
          w_state_nxt = ST_H_TRACK;
        end
      end
      ST_H_TRACK: begin
        if (w_h_sat_hit) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_frame_evt && w_frame_ok &&
                     (w_match_nxt >= LOCK_LINES_L)) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if ((w_h_edge && !w_line_ok) ||
            (w_frame_evt && !w_frame_ok) ||
            w_h_sat_hit) begin
          w_state_nxt = ST_SEARCH;
          w_sync_err  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and measurements
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkPort) begin
    if (!Reset_n) begin
      r_state       <= ST_SEARCH;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_pending     <= 1'b0;
      r_match       <= '0;
    end else if (pix_en) begin
      r_state <= w_state_nxt;

      if (w_h_edge) begin
        r_hcount   <= '0;
        r_line_len <= w_hcount_inc;
      end else begin
        r_hcount   <= w_hcount_inc;
      end

      if (w_frame_evt) begin
        r_vcount      <= '0;
        r_frame_lines <= w_vcount_inc;
        r_pending     <= 1'b0;
      end else begin
        if (w_h_edge) begin
          r_vcount <= w_vcount_inc;
        end
        if (w_v_edge) begin
          r_pending <= 1'b1;
        end
      end

      // Only meaningful while tracking; entering H_TRACK starts from zero.
      if (r_state == ST_H_TRACK) begin
        if (w_h_edge) begin
          r_match <= w_match_nxt;
        end
      end else begin
        r_match <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hCount      = r_hcount;
  assign vCount      = r_vcount;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign locked      = (r_state == ST_LOCKED);

  assign bright = locked &&
                  (r_hcount >= H_ACT_START_L) && (r_hcount <= H_ACT_END_L) &&
                  (r_vcount >= V_ACT_START_L) && (r_vcount <= V_ACT_END_L);

  // Pulses are strobes of the pixel sample itself, so they only ever appear
  // in pix_en cycles; reset masks them while it is asserted.
  assign frame_start = w_frame_evt & Reset_n;
  assign sync_err    = w_sync_err & Reset_n;

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter H_TOTAL, default 800, expected pixel periods per line.
REQ-002 Parameter V_TOTAL, default 525, expected lines per frame.
REQ-003 Parameters H_ACT_START/H_ACT_END, default 144/783, inclusive active pixel window.
REQ-004 Parameters V_ACT_START/V_ACT_END, default 35/514, inclusive active line window.
REQ-005 Parameter LOCK_LINES, default 4, consecutive matching lines required before frame check.
REQ-006 Port ClkPort  in  1  system clock (100 MHz); single clock domain; one clock, all logic on its rising edge.
REQ-007 Port Reset_n  in  1  reset, synchronous, active-low.
REQ-008 Port pix_en  in  1  pixel-rate enable (one ClkPort cycle in four); all sampling/counting occurs only on pix_en=1 cycles.
REQ-009 Port hSync  in  1  active-low horizontal sync, already synchronous to ClkPort.
REQ-010 Port vSync  in  1  active-low vertical sync, already synchronous to ClkPort.
REQ-011 Port hCount  out  10  recovered pixel position in the line.
REQ-012 Port vCount  out  10  recovered line position in the frame.
REQ-013 Port bright  out  1  recovered active-video flag.
REQ-014 Port locked  out  1  timing matches H_TOTAL/V_TOTAL.
REQ-015 Port line_len  out  10  last measured line length in pixel periods.
REQ-016 Port frame_lines  out  10  last measured frame length in lines.
REQ-017 Port frame_start  out  1  one-ClkPort-cycle pulse at each recovered vCount=0 start.
REQ-018 Port sync_err  out  1  one-ClkPort-cycle pulse on loss of lock.

Function
REQ-019 hSync edge: the pix_en sample where hSync=0 and the previous pix_en sample had hSync=1; vSync edge defined likewise.
REQ-020 On an hSync edge hCount loads 0; on other pix_en samples it increments, saturating at 1023.
REQ-021 On an hSync edge line_len loads hCount+1 (saturated at 1023), registered in the same cycle as the hCount reload.
REQ-022 A vSync edge sets a pending flag; on the same-or-next hSync edge with the flag set, vCount loads 0, frame_lines loads vCount+1, frame_start pulses and the flag clears.
REQ-023 On an hSync edge without a pending flag vCount increments, saturating at 1023.
REQ-024 Simultaneous hSync and vSync edges on one sample: vCount loads 0 on that sample.
REQ-025 State machine SEARCH -> H_TRACK on first hSync edge; line-match counter clears.
REQ-026 H_TRACK: each hSync edge with hCount+1=H_TOTAL increments the match counter, any other value clears it; on match count >= LOCK_LINES, the next frame_start with frame_lines=V_TOTAL enters LOCKED; a frame_start with another frame_lines value stays in H_TRACK.
REQ-027 LOCKED: locked=1; any hSync edge with hCount+1 != H_TOTAL, any frame_start with frame_lines != V_TOTAL, or hCount reaching 1023 -> SEARCH with sync_err pulse.
REQ-028 H_TRACK: hCount reaching 1023 -> SEARCH without sync_err.
REQ-029 bright=1 only when locked=1 and H_ACT_START<=hCount<=H_ACT_END and V_ACT_START<=vCount<=V_ACT_END; combinational from registered state, no extra latency.
REQ-030 Outputs hold their values on pix_en=0 cycles; frame_start/sync_err are asserted only in pix_en=1 cycles.

Reset
REQ-031 Reset_n=0 at a ClkPort edge: state=SEARCH; hCount, vCount, line_len, frame_lines, match counter = 0; locked, bright, frame_start, sync_err, pending flag = 0; previous-sync samples = 1.
REQ-032 Reset overrides pix_en and mid-line or mid-frame activity; the first hSync edge after release is treated as REQ-025.

Structure
REQ-033 Default timing constants (800/525/144/783/35/514) shall live in a shared package vga_timing_pkg also used by display_controller; the state enumeration belongs there as well.
REQ-034 One sub-module, sync_edge_det (pix_en-qualified falling-edge detector), instantiated twice for hSync and vSync; all else is flat.

Verification
REQ-035 Standard 640x480 stream (hSync low hCount 0-95, vSync low lines 0-1) -> locked=1 within 2 frames, line_len=800, frame_lines=525, hCount/vCount match the generator's counts every pixel.
REQ-036 Locked stream, one line shortened to 799 -> sync_err one pulse at that hSync edge, locked=0, line_len=799; relock after LOCK_LINES good lines plus one good frame.
REQ-037 hSync held high after lock -> hCount saturates at 1023, sync_err pulses once, state SEARCH, no further pulses.
REQ-038 vSync edge on the same sample as hSync edge -> vCount=0 on that sample, frame_start single pulse; vSync edge 10 pixels after hSync edge -> vCount=0 at the next hSync edge.
REQ-039 Reset_n=0 for one ClkPort cycle mid-frame while locked -> all outputs 0 next cycle, locked returns only after full relock sequence.
REQ-040 Pixel at hCount=144, vCount=35 -> bright=1; hCount=784 or vCount=515 -> bright=0; bright=0 throughout while unlocked.
